// File: rtl/triangle_dispatcher_if.sv
// Dispatcher bus: frame control, vertex-memory read port and rasterizer handshake.
interface triangle_dispatcher_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
);
  logic                  frame_start;
  logic [ADDR_W-1:0]     base_addr;
  logic [CNT_W-1:0]      tri_count;
  logic [ADDR_W-1:0]     mem_addr;
  logic [31:0]           mem_rdata;
  logic [2:0][31:0]      p1, p2, p3;
  logic [3:0]            color;
  logic                  rast_start;
  logic                  rast_done;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output frame_start, base_addr, tri_count, mem_rdata, rast_done,
    input  mem_addr, p1, p2, p3, color, rast_start, busy, frame_done
  );

  modport slave (
    input  frame_start, base_addr, tri_count, mem_rdata, rast_done,
    output mem_addr, p1, p2, p3, color, rast_start, busy, frame_done
  );
endinterface

// File: rtl/triangle_dispatcher.sv
// Triangle dispatcher: fetches 10-word triangle records into a one-entry
// shadow, then loads them onto the rasterizer inputs and runs start/done.
module triangle_dispatcher #(
  parameter int ADDR_W        = 12,
  parameter int CNT_W         = 8,
  parameter int WORDS_PER_TRI = 10
) (
  input logic                 clk,
  input logic                 areset,
  triangle_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {F_IDLE, F_READ, F_FULL} fstate_t;
  typedef enum logic [2:0] {I_IDLE, I_LOAD, I_START, I_WAIT_LOW, I_WAIT_HIGH} istate_t;

  // phase counts cycles inside F_READ: address word p is on mem_addr in
  // phase p, its data arrives in phase p+1; phase 10 carries ctrl.
  localparam logic [3:0] PH_LAST_ADDR = 4'(WORDS_PER_TRI - 1);
  localparam logic [3:0] PH_CTRL      = 4'(WORDS_PER_TRI);

  fstate_t             fstate;
  istate_t             istate;
  logic [3:0]          phase;
  logic [ADDR_W-1:0]   rd_base;
  logic [CNT_W-1:0]    fetch_idx;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    done_cnt;
  logic [8:0][31:0]    sh_w;
  logic [3:0]          sh_color;
  logic                sh_vld;

  logic [ADDR_W-1:0]   mem_addr_q;
  logic [2:0][31:0]    p1_q, p2_q, p3_q;
  logic [3:0]          color_q;
  logic                rast_start_q, busy_q, frame_done_q;

  logic                start_ok, consume, issue_done, skip_done, more;
  logic [CNT_W:0]      done_nxt;
  logic [ADDR_W-1:0]   nxt_base;
  logic [3:0]          widx;

  assign start_ok   = bus.frame_start && !busy_q;
  assign consume    = (istate == I_LOAD);
  assign issue_done = (istate == I_WAIT_HIGH) && bus.rast_done;
  assign skip_done  = (fstate == F_READ) && (phase == PH_CTRL) && bus.mem_rdata[31];
  assign more       = ({1'b0, fetch_idx} + (CNT_W+1)'(1)) < {1'b0, cnt_r};
  assign done_nxt   = {1'b0, done_cnt} + (CNT_W+1)'(issue_done) + (CNT_W+1)'(skip_done);
  assign nxt_base   = rd_base + ADDR_W'(WORDS_PER_TRI);
  assign widx       = phase - 4'd1;

  // Fetch FSM: walk records, fill the shadow, drop skipped records.
  always_ff @(posedge clk) begin
    if (areset) begin
      fstate     <= F_IDLE;
      phase      <= '0;
      rd_base    <= '0;
      fetch_idx  <= '0;
      mem_addr_q <= '0;
      sh_w       <= '0;
      sh_color   <= '0;
      sh_vld     <= 1'b0;
    end else begin
      case (fstate)
        F_IDLE: begin
          if (start_ok && bus.tri_count != '0) begin
            rd_base    <= bus.base_addr;
            mem_addr_q <= bus.base_addr;
            phase      <= '0;
            fetch_idx  <= '0;
            fstate     <= F_READ;
          end
        end
        F_READ: begin
          phase <= phase + 4'd1;
          if (phase < PH_LAST_ADDR)
            mem_addr_q <= rd_base + ADDR_W'(phase) + ADDR_W'(1);
          if (phase != 4'd0 && phase < PH_CTRL)
            sh_w[widx] <= bus.mem_rdata;
          if (phase == PH_CTRL) begin
            if (bus.mem_rdata[31]) begin
              if (more) begin
                rd_base    <= nxt_base;
                mem_addr_q <= nxt_base;
                phase      <= '0;
                fetch_idx  <= fetch_idx + CNT_W'(1);
              end else begin
                fstate <= F_IDLE;
              end
            end else begin
              sh_color <= bus.mem_rdata[3:0];
              sh_vld   <= 1'b1;
              fstate   <= F_FULL;
            end
          end
        end
        F_FULL: begin
          if (consume) begin
            sh_vld <= 1'b0;
            if (more) begin
              rd_base    <= nxt_base;
              mem_addr_q <= nxt_base;
              phase      <= '0;
              fetch_idx  <= fetch_idx + CNT_W'(1);
              fstate     <= F_READ;
            end else begin
              fstate <= F_IDLE;
            end
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // Issue FSM: load outputs from the shadow, pulse start, wait for done.
  always_ff @(posedge clk) begin
    if (areset) begin
      istate       <= I_IDLE;
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      color_q      <= '0;
      rast_start_q <= 1'b0;
    end else begin
      case (istate)
        I_IDLE: if (sh_vld && bus.rast_done) istate <= I_LOAD;
        I_LOAD: begin
          p1_q         <= {sh_w[2], sh_w[1], sh_w[0]};
          p2_q         <= {sh_w[5], sh_w[4], sh_w[3]};
          p3_q         <= {sh_w[8], sh_w[7], sh_w[6]};
          color_q      <= sh_color;
          rast_start_q <= 1'b1;
          istate       <= I_START;
        end
        I_START: begin
          rast_start_q <= 1'b0;
          istate       <= I_WAIT_LOW;
        end
        I_WAIT_LOW:  if (!bus.rast_done) istate <= I_WAIT_HIGH;
        I_WAIT_HIGH: if (bus.rast_done)  istate <= I_IDLE;
        default:     istate <= I_IDLE;
      endcase
    end
  end

  // Frame control: accept frames, count completions, pulse frame_done.
  always_ff @(posedge clk) begin
    if (areset) begin
      cnt_r        <= '0;
      done_cnt     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (start_ok) begin
        cnt_r    <= bus.tri_count;
        done_cnt <= '0;
        if (bus.tri_count == '0) frame_done_q <= 1'b1;
        else                     busy_q       <= 1'b1;
      end else if (busy_q) begin
        done_cnt <= done_nxt[CNT_W-1:0];
        if (done_nxt == {1'b0, cnt_r}) begin
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.p1         = p1_q;
  assign bus.p2         = p2_q;
  assign bus.p3         = p3_q;
  assign bus.color      = color_q;
  assign bus.rast_start = rast_start_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Scoreboard bench for triangle_dispatcher with memory and rasterizer models.
module tb_triangle_dispatcher;
  localparam int AW = 12;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic areset = 1'b1;
  triangle_dispatcher_if #(.ADDR_W(AW), .CNT_W(CW)) bus();
  triangle_dispatcher #(.ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .areset(areset), .bus(bus));

  always #5 clk = ~clk;

  // Vertex memory: one-cycle read latency.
  logic [31:0] mem [0:4095];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  // Rasterizer model: idle-high done, low for run_len cycles after start.
  int   run_len = 60;
  int   rcnt = 0;
  logic rdone = 1'b1;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    if (areset) begin
      rdone <= 1'b1; rcnt <= 0;
    end else if (bus.rast_start) begin
      rdone <= 1'b0; rcnt <= run_len;
    end else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) rdone <= 1'b1;
    end
  end
  assign bus.rast_done = rdone & ~hold_low;

  typedef struct packed { logic [95:0] p1, p2, p3; logic [3:0] c; } tri_t;
  tri_t exp_q[$];
  int   exp_fd = 0, n_fd = 0, n_start = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ra(input logic [AW-1:0] b, input int i, input int k);
    return AW'(int'(b) + i * 10 + k);
  endfunction

  // Reference model: every non-skipped record, in order, then one frame_done.
  task automatic expect_frame(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tri_t t;
      logic [31:0] ctrl;
      ctrl = mem[ra(b, i, 9)];
      if (ctrl[31]) continue;
      t.p1 = {mem[ra(b, i, 2)], mem[ra(b, i, 1)], mem[ra(b, i, 0)]};
      t.p2 = {mem[ra(b, i, 5)], mem[ra(b, i, 4)], mem[ra(b, i, 3)]};
      t.p3 = {mem[ra(b, i, 8)], mem[ra(b, i, 7)], mem[ra(b, i, 6)]};
      t.c  = ctrl[3:0];
      exp_q.push_back(t);
    end
    exp_fd++;
  endtask

  task automatic fill(input logic [AW-1:0] b, input int i, input logic skip);
    for (int k = 0; k < 9; k++) mem[ra(b, i, k)] = $urandom;
    mem[ra(b, i, 9)] = {skip, 27'($urandom), 4'($urandom)};
  endtask

  task automatic cyc_step();
    @(negedge clk); #1;
  endtask

  task automatic start_frame(input logic [AW-1:0] b, input int n);
    expect_frame(b, n);
    cyc_step();
    bus.frame_start = 1'b1; bus.base_addr = b; bus.tri_count = CW'(n);
    cyc_step();
    bus.frame_start = 1'b0; bus.base_addr = AW'($urandom); bus.tri_count = CW'($urandom);
  endtask

  task automatic wait_frame(input string nm);
    int f0, t;
    f0 = n_fd; t = 0;
    while (n_fd == f0 && t < 2000) begin cyc_step(); t++; end
    chk(nm, 128'(n_fd != f0), 128'(1));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, 128'(bus.busy), 128'(0));
    chk({nm, "_fd"}, 128'(bus.frame_done), 128'(0));
    chk({nm, "_start"}, 128'(bus.rast_start), 128'(0));
    chk({nm, "_addr"}, 128'(bus.mem_addr), 128'(0));
    chk({nm, "_pts"}, 128'({bus.p1, bus.p2, bus.p3}), 128'(0));
    chk({nm, "_color"}, 128'(bus.color), 128'(0));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    exp_q.delete(); exp_fd = 0;
    cyc_step();
    chk_reset("areset");
    areset = 1'b0;
  endtask

  // Monitor: compare every start against the scoreboard, check stability.
  tri_t cur, snap, e;
  logic act = 1'b0, lowseen = 1'b0, bad = 1'b0;
  assign cur = {bus.p1, bus.p2, bus.p3, bus.color};
  always @(negedge clk) begin
    if (areset) begin
      act = 1'b0;
    end else begin
      if (bus.rast_start) begin
        n_start++;
        chk("start_while_done_hi", 128'(bus.rast_done), 128'(1));
        if (exp_q.size() == 0) chk("unexpected_start", 128'(1), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("p1", 128'(bus.p1), 128'(e.p1));
          chk("p2", 128'(bus.p2), 128'(e.p2));
          chk("p3", 128'(bus.p3), 128'(e.p3));
          chk("color", 128'(bus.color), 128'(e.c));
        end
        snap = cur; act = 1'b1; lowseen = 1'b0; bad = 1'b0;
      end else if (act) begin
        if (cur != snap) bad = 1'b1;
        if (!bus.rast_done) lowseen = 1'b1;
        else if (lowseen) begin
          chk("stable_during_run", 128'(bad), 128'(0));
          act = 1'b0;
        end
      end
      if (bus.frame_done) begin
        n_fd++;
        chk("fd_expected", 128'(exp_fd > 0), 128'(1));
        if (exp_fd > 0) exp_fd--;
        chk("fd_all_issued", 128'(exp_q.size()), 128'(0));
        chk("fd_busy_low", 128'(bus.busy), 128'(0));
      end
    end
  end

  initial begin
    int st, t, s0, f0, seen;
    logic [AW-1:0] b, a0;
    bus.frame_start = 1'b0; bus.base_addr = '0; bus.tri_count = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    repeat (3) cyc_step();
    chk_reset("reset");
    areset = 1'b0;

    // Single record at 0x010: address timing, start at cycle 14, done timing.
    fill(12'h010, 0, 1'b0);
    run_len = 60;
    s0 = n_start;
    start_frame(12'h010, 1);
    st = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 10) chk("single_addr", 128'(bus.mem_addr), 128'(12'h010 + k - 1));
      if (bus.rast_start && st < 0) st = k;
      if (k < 20) cyc_step();
    end
    chk("single_start_cycle", 128'(st), 128'(14));
    t = 0;
    while (!bus.rast_done && t < 200) begin cyc_step(); t++; end
    chk("single_fd_not_at_rise", 128'(bus.frame_done), 128'(0));
    cyc_step();
    chk("single_fd_after_rise", 128'(bus.frame_done), 128'(1));
    chk("single_starts", 128'(n_start - s0), 128'(1));

    // Three records: prefetch of record 1 overlaps record 0's run.
    b = 12'h200;
    for (int i = 0; i < 3; i++) fill(b, i, 1'b0);
    s0 = n_start;
    start_frame(b, 3);
    t = 0;
    while (n_start == s0 && t < 60) begin cyc_step(); t++; end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.mem_addr == ra(b, 1, 9) && !bus.rast_done) seen = 1;
      cyc_step();
    end
    chk("prefetch_overlap", 128'(seen), 128'(1));
    wait_frame("three_fd");
    chk("three_starts", 128'(n_start - s0), 128'(3));

    // Middle record skipped.
    b = 12'h300;
    for (int i = 0; i < 3; i++) fill(b, i, 1'b0);
    mem[ra(b, 1, 9)] = 32'h8000_000F;
    s0 = n_start;
    start_frame(b, 3);
    wait_frame("skip_fd");
    chk("skip_starts", 128'(n_start - s0), 128'(2));

    // Every record skipped.
    b = 12'h400;
    for (int i = 0; i < 3; i++) fill(b, i, 1'b1);
    s0 = n_start;
    start_frame(b, 3);
    wait_frame("allskip_fd");
    chk("allskip_starts", 128'(n_start - s0), 128'(0));

    // Zero-count frame.
    a0 = bus.mem_addr;
    start_frame(12'h555, 0);
    chk("zero_fd", 128'(bus.frame_done), 128'(1));
    chk("zero_busy", 128'(bus.busy), 128'(0));
    chk("zero_addr", 128'(bus.mem_addr), 128'(a0));
    cyc_step();
    chk("zero_busy_after", 128'(bus.busy), 128'(0));

    // frame_start while busy is ignored.
    b = 12'h600;
    for (int i = 0; i < 2; i++) fill(b, i, 1'b0);
    s0 = n_start; f0 = n_fd;
    start_frame(b, 2);
    repeat (5) cyc_step();
    bus.frame_start = 1'b1; bus.base_addr = 12'h700; bus.tri_count = 8'd4;
    cyc_step();
    bus.frame_start = 1'b0;
    wait_frame("ignore_fd");
    repeat (100) cyc_step();
    chk("ignore_starts", 128'(n_start - s0), 128'(2));
    chk("ignore_fds", 128'(n_fd - f0), 128'(1));

    // Address wrap.
    fill(12'hFFC, 0, 1'b0);
    start_frame(12'hFFC, 1);
    for (int k = 1; k <= 10; k++) begin
      chk("wrap_addr", 128'(bus.mem_addr), 128'(ra(12'hFFC, 0, k - 1)));
      cyc_step();
    end
    wait_frame("wrap_fd");

    // Issue stalls while rast_done is low in idle.
    hold_low = 1'b1;
    fill(12'h100, 0, 1'b0);
    s0 = n_start;
    start_frame(12'h100, 1);
    repeat (40) cyc_step();
    chk("stall_no_start", 128'(n_start - s0), 128'(0));
    hold_low = 1'b0;
    wait_frame("stall_fd");
    chk("stall_starts", 128'(n_start - s0), 128'(1));

    // Reset while rasterizing.
    b = 12'h800;
    for (int i = 0; i < 3; i++) fill(b, i, 1'b0);
    s0 = n_start;
    start_frame(b, 3);
    t = 0;
    while (n_start == s0 && t < 60) begin cyc_step(); t++; end
    repeat (10) cyc_step();
    do_reset();
    s0 = n_start; f0 = n_fd;
    repeat (150) cyc_step();
    chk("rst_run_no_start", 128'(n_start - s0), 128'(0));
    chk("rst_run_no_fd", 128'(n_fd - f0), 128'(0));

    // Reset while fetching.
    start_frame(b, 2);
    repeat (4) cyc_step();
    do_reset();
    s0 = n_start; f0 = n_fd;
    repeat (100) cyc_step();
    chk("rst_read_no_start", 128'(n_start - s0), 128'(0));
    chk("rst_read_no_fd", 128'(n_fd - f0), 128'(0));

    // Normal frame after reset.
    fill(12'h020, 0, 1'b0);
    s0 = n_start;
    start_frame(12'h020, 1);
    wait_frame("post_rst_fd");
    chk("post_rst_starts", 128'(n_start - s0), 128'(1));

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      int n;
      b = AW'($urandom);
      n = int'($urandom_range(1, 5));
      run_len = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) fill(b, i, ($urandom_range(0, 3) == 0));
      start_frame(b, n);
      wait_frame("rand_fd");
    end

    repeat (5) cyc_step();
    chk("end_q_empty", 128'(exp_q.size()), 128'(0));
    chk("end_fd_pending", 128'(exp_fd), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
